// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 multiplexer datapath.
// Grants one of four requesters, drives the mux select and registers
// the selected lane data together with a valid flag.
module mux_rr_arbiter #(
    parameter int WIDTH    = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] x,
    output logic             x_valid,
    output logic             busy
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;

    logic [4*WIDTH-1:0] lanes_flat;
    logic [WIDTH-1:0]   lane [4];

    logic [2:0] srch_idle;
    logic [2:0] srch_grant;
    logic       grant_en;
    logic [1:0] grant_idx;

    // Lane 0 is a, lane 3 is d.
    assign lanes_flat = {d, c, b, a};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = lanes_flat[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Returns {found, index} of the first set request scanning from start;
    // with skip_first the start lane itself is excluded.
    function automatic logic [2:0] find_req(input logic [3:0] r,
                                            input logic [1:0] start,
                                            input logic       skip_first);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx] && !(skip_first && k == 0)) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Next-state: arbitration decision plus datapath capture.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        x_d       = lane[sel_q];
        x_valid_d = (state_q == GRANT) && req[sel_q];
        grant_en  = 1'b0;
        grant_idx = 2'd0;

        srch_idle  = find_req(req, ptr_q, 1'b0);
        srch_grant = find_req(req, sel_q, 1'b1);

        case (state_q)
            IDLE: begin
                if (srch_idle[2]) begin
                    grant_en  = 1'b1;
                    grant_idx = srch_idle[1:0];
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    // Current owner released: hand off without a bubble if possible.
                    if (srch_grant[2]) begin
                        grant_en  = 1'b1;
                        grant_idx = srch_grant[1:0];
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                        cnt_d   = 4'd0;
                    end
                end else if (cnt_q == MAX_HOLD_C && (req & ~gnt_q) != 4'b0000) begin
                    // Hold budget spent and someone else waits: rotate.
                    grant_en  = 1'b1;
                    grant_idx = srch_grant[1:0];
                end else if (cnt_q != MAX_HOLD_C) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant_en) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << grant_idx;
            sel_d   = grant_idx;
            cnt_d   = 4'd1;
            ptr_d   = grant_idx + 2'd1;
            busy_d  = 1'b1;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            cnt_q     <= 4'd0;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            x_q       <= '0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: stimulus pushes model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mux_rr_arbiter;

    localparam int WIDTH    = 2;
    localparam int MAX_HOLD = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       req;
    logic [WIDTH-1:0] a, b, c, d;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] x;
    logic             x_valid;
    logic             busy;

    mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a(a), .b(b), .c(c), .d(d),
        .gnt(gnt), .sel(sel), .x(x), .x_valid(x_valid), .busy(busy)
    );

    typedef struct {
        int gnt;
        int sel;
        int busy;
        int x;
        int xv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    bit   log_en = 0;
    int   gnt_hist[$];

    // Reference model: owner (-1 = nobody), cycles held, rotation pointer, last select.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    int m_sel   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_sel   = 0;
    endtask

    function automatic int first_from(input logic [3:0] r, input int start, input int n_skip);
        for (int k = n_skip; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    // Advances the model by one clock edge for the given inputs; returns expected outputs.
    function automatic exp_t model_step(input logic [3:0] r, input int lv[4]);
        exp_t e;
        int   w;
        e.x  = lv[m_sel];
        e.xv = (m_owner >= 0 && r[m_sel]) ? 1 : 0;
        w    = -1;
        if (m_owner < 0) begin
            w = first_from(r, m_ptr, 0);
        end else if (!r[m_owner]) begin
            w = first_from(r, m_owner, 1);
            if (w < 0) begin
                m_owner = -1;
                m_held  = 0;
            end
        end else if (m_held >= MAX_HOLD && (r & ~(4'b1 << m_owner)) != 0) begin
            w = first_from(r, m_owner, 1);
        end else begin
            m_held = (m_held + 1 > MAX_HOLD) ? MAX_HOLD : m_held + 1;
        end
        if (w >= 0) begin
            m_owner = w;
            m_held  = 1;
            m_sel   = w;
            m_ptr   = (w + 1) % 4;
        end
        e.gnt  = (m_owner >= 0) ? (1 << m_owner) : 0;
        e.sel  = m_sel;
        e.busy = (m_owner >= 0) ? 1 : 0;
        return e;
    endfunction

    // One transaction: called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input logic [3:0] r, input logic [1:0] va, input logic [1:0] vb,
                         input logic [1:0] vc, input logic [1:0] vd);
        int   lv[4];
        exp_t e;
        req = r; a = va; b = vb; c = vc; d = vd;
        lv[0] = va; lv[1] = vb; lv[2] = vc; lv[3] = vd;
        e = model_step(r, lv);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic cycle_r(input logic [3:0] r);
        cycle(r, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    endtask

    // Asynchronous reset between edges, checked before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_sel", sel, 0);
        chk("rst_x", x, 0);
        chk("rst_xvalid", x_valid, 0);
        chk("rst_busy", busy, 0);
        req = 4'b0000;
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: each output cycle pops the matching expectation.
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            txn++;
            $display("txn %0d: req=%b gnt=%b sel=%0d busy=%0d x=%0d x_valid=%0d", txn, req, gnt, sel, busy, x, x_valid);
            chk("gnt", gnt, e.gnt);
            chk("sel", sel, e.sel);
            chk("busy", busy, e.busy);
            chk("x_valid", x_valid, e.xv);
            if (e.xv != 0) chk("x", x, e.x);
            chk("onehot", $countones(gnt) <= 1, 1);
            if (busy) chk("gnt_at_sel", gnt[sel], 1);
            if (log_en) gnt_hist.push_back(int'(gnt));
        end
    end

    initial begin
        logic [3:0] r;
        rst = 1'b1;
        req = 4'b0000;
        a = 0; b = 0; c = 0; d = 0;
        #1;
        chk("init_gnt", gnt, 0);
        chk("init_busy", busy, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single request on lane C for three cycles, then idle.
        for (int i = 0; i < 3; i++) cycle(4'b0100, 2'd0, 2'd1, 2'b10, 2'd3);
        for (int i = 0; i < 3; i++) cycle(4'b0000, 2'd0, 2'd1, 2'b10, 2'd3);
        // ptr is now 3: lane D wins a full request set.
        cycle_r(4'b1111);
        cycle_r(4'b0000);
        cycle_r(4'b0000);

        // Fairness from a fresh reset with everyone requesting.
        do_reset();
        gnt_hist.delete();
        log_en = 1;
        for (int i = 0; i < 17; i++) cycle_r(4'b1111);
        @(negedge clk);
        #1;
        log_en = 0;
        chk("fair_len", gnt_hist.size(), 17);
        for (int i = 0; i < gnt_hist.size() && i < 17; i++)
            chk("fair_seq", gnt_hist[i], 1 << ((i / MAX_HOLD) % 4));

        // Handoff: lane 0 drops after two granted cycles, lane 3 takes over at once.
        do_reset();
        cycle_r(4'b1001);
        cycle_r(4'b1001);
        cycle_r(4'b1000);
        cycle_r(4'b1000);
        cycle_r(4'b0000);

        // Lone holder keeps grant past MAX_HOLD, then rotates as soon as D asks.
        for (int i = 0; i < 10; i++) cycle_r(4'b0010);
        cycle_r(4'b1010);
        cycle_r(4'b1010);
        cycle_r(4'b0000);
        cycle_r(4'b0000);

        // Pointer wrap: grant lane 3, release, then 0 and 3 compete.
        cycle_r(4'b1000);
        cycle_r(4'b0000);
        cycle_r(4'b1001);
        cycle_r(4'b1001);
        cycle_r(4'b0000);

        // Request dropping at the edge its grant is issued.
        cycle_r(4'b0001);
        cycle_r(4'b0000);
        cycle_r(4'b0000);

        // Randomised traffic with sticky request patterns.
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            cycle_r(r);
            if (i == 300) do_reset();
        end
        // Reset right in the middle of a grant.
        cycle_r(4'b0110);
        cycle_r(4'b0110);
        do_reset();
        for (int i = 0; i < 6; i++) cycle_r(4'b1111);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
